// File: rtl/downsizing.sv
// Width-halving stream stage: each 2W-bit word leaves as two W-bit beats, upper half first.
// A one-entry skid register keeps in_tready a pure flop output.
module downsizing #(
   parameter int W = 40
) (
   input  logic           aclk,
   input  logic           areset,
   input  logic [2*W-1:0] in_tdata,
   input  logic           in_tvalid,
   output logic           in_tready,
   output logic [W-1:0]   out_tdata,
   output logic           out_tvalid,
   input  logic           out_tready,
   output logic           out_tlast
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HI   = 2'd1,
      LO   = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [2*W-1:0] data_r;
   logic [2*W-1:0] data_nx;
   logic [2*W-1:0] skid_data;
   logic [2*W-1:0] skid_nx;
   logic           skid_valid;
   logic           skid_valid_nx;

   logic in_hs;
   logic out_hs;
   logic main_free;

   assign in_tready  = ~skid_valid;
   assign out_tvalid = (state != IDLE);
   assign out_tlast  = (state == LO);
   assign out_tdata  = (state == LO) ? data_r[W-1:0] : data_r[2*W-1:W];

   assign in_hs     = in_tvalid & in_tready;
   assign out_hs    = out_tvalid & out_tready;
   assign main_free = (state == IDLE) | ((state == LO) & out_hs);

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state      <= IDLE;
         data_r     <= '0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         data_r     <= data_nx;
         skid_data  <= skid_nx;
         skid_valid <= skid_valid_nx;
      end
   end

   // Skid drains before new input so word order is preserved.
   always_comb begin
      state_nx      = state;
      data_nx       = data_r;
      skid_nx       = skid_data;
      skid_valid_nx = skid_valid;
      if ((state == HI) && out_hs) begin
         state_nx = LO;
      end
      if (main_free) begin
         if (skid_valid) begin
            data_nx       = skid_data;
            skid_valid_nx = 1'b0;
            state_nx      = HI;
         end else if (in_hs) begin
            data_nx  = in_tdata;
            state_nx = HI;
         end else begin
            state_nx = IDLE;
         end
      end else if (in_hs) begin
         skid_nx       = in_tdata;
         skid_valid_nx = 1'b1;
      end
   end

endmodule

// File: doc/downsizing.md
# downsizing

Width-halving AXI-Stream-style stage. It accepts `2*W`-bit words and emits each one as two `W`-bit beats, upper half first and lower half second. The block is the inverse of `upsizing`, placed directly downstream of it, so the pair `upsizing` → `downsizing` restores the original `W`-bit stream in order. A one-entry skid register keeps `in_tready` a pure flop output, so there is no combinational `out_tready` → `in_tready` path, while the output still sustains one beat per cycle.

## Interface
- `W`, default 40: width of an output beat; the input word is `2*W`.
- `aclk`  input  1  clock; all state changes on the rising edge.
- `areset`  input  1  asynchronous, active-high reset.
- `in_tdata`  input  2*W  wide word; bits `[2W-1:W]` are sent first.
- `in_tvalid`  input  1  upstream word valid.
- `in_tready`  output  1  block can take a word; driven directly by a register.
- `out_tdata`  output  W  current half-word.
- `out_tvalid`  output  1  `out_tdata` valid.
- `out_tready`  input  1  downstream accepts the beat.
- `out_tlast`  output  1  high while the lower (second) half is presented.

## Operation
- Storage:
  - main register `data_r[2W-1:0]`;
  - state `IDLE` / `HI` / `LO`;
  - skid register `skid_data[2W-1:0]` with flag `skid_valid`.
- Outputs:
  - `out_tvalid = (state != IDLE)`.
  - `out_tdata = data_r[2W-1:W]` in `HI`, `data_r[W-1:0]` in `LO`, and `data_r[2W-1:W]` in `IDLE` (don't-care).
  - `out_tlast = (state == LO)`.
  - `in_tready = ~skid_valid`.
- Definitions:
  - `in_hs = in_tvalid & in_tready`
  - `out_hs = out_tvalid & out_tready`
  - `main_free = (state == IDLE) | (state == LO & out_hs)`
- State transitions:
  - `HI` & `out_hs` → `LO`.
  - `HI` & no `out_hs`, or `LO` & no `out_hs` → hold; `data_r` and `out_tdata` stay stable.
  - `main_free` & `skid_valid` → load `data_r` from `skid_data`, clear `skid_valid`, go to `HI`.
  - `main_free` & `in_hs` (implies `~skid_valid`) → load `data_r` from `in_tdata`, go to `HI`.
  - `~main_free` & `in_hs` → `skid_data <= in_tdata`, `skid_valid <= 1`.
  - `main_free` with nothing to load → `IDLE`.
- Skid has priority over new input. No conflict is possible because `in_tready = 0` whenever `skid_valid = 1`.
- Ordering is strict FIFO: main, then skid, then new input. Beats are never dropped, duplicated or reordered.
- Handshake rules:
  - `out_tvalid` never drops without `out_hs`.
  - `out_tdata` and `out_tlast` are stable while `out_tvalid & ~out_tready`.
  - `in_tready` does not depend combinationally on `in_tvalid` or `out_tready`.

## Timing
- Reset (asynchronous, immediate while `areset = 1`):
  - state `IDLE`, `skid_valid = 0`, `data_r = 0`, `skid_data = 0`;
  - hence `out_tvalid = 0`, `out_tlast = 0`, `out_tdata = 0`, `in_tready = 1`.
- Reset mid-transfer discards the main register and the skid contents; there is no partial output afterwards.
- Latency: a word accepted at edge k with `main_free` drives `out_tvalid = 1` with its upper half after edge k (1 cycle).
- Throughput with `out_tready` held high: one output beat every cycle, with `out_tvalid` never gapping while input is back-to-back. Input is accepted on average every 2 cycles, and `in_tready` alternates 1/0.
- Full condition: `state != IDLE` and `skid_valid` means 2 words in flight, and `in_tready = 0`.
- Empty condition: `IDLE` and `~skid_valid`.
- Simultaneous events:
  - `LO` & `out_hs` & `in_hs` at the same edge → new word goes straight to main in `HI`; no bubble.
  - `LO` & `out_hs` & `skid_valid` → skid moves to main and `in_tready` rises after that edge.

## Test plan
- **Single word, ready high.** Reset, then send `"ABCDEFGHIJ"` (W=40 ASCII). Required: out `"ABCDE"` (`tlast = 0`) at cycle k+1, then `"FGHIJ"` (`tlast = 1`) at k+2, then `out_tvalid = 0`.
- **Back-to-back input, ready high.** Send 3 words `"ABCDEFGHIJ"`, `"KLMNOPQRST"`, `"UVWXYZabcd"` with `in_tvalid` held high. Required: 6 consecutive output beats with no gap, in order, `tlast` on beats 2/4/6, and `in_tready` toggling 1,1,0,1,0,…
- **Backpressure.** Same 3 words with `out_tready` = 0,1,0,1…. Required: identical beat sequence, `out_tdata` stable during each stall, `in_tready = 0` whenever main and skid are both occupied.
- **Random sweep.** Random `in_tvalid` gaps (0–5 cycles) and random `out_tready` for 1000 cycles, with a scoreboard that splits each accepted input into upper and lower halves. Required: every output beat matches and the queue is empty at the end.
- **Reset mid-operation.** Assert `areset` between edges while in `LO` with `skid_valid = 1`. Required: immediately `out_tvalid = 0`, `in_tready = 1`, `out_tdata = 0`; after release, a new word `"0123456789"` emits `"01234"` and then `"56789"` with no stale beats.
